// File: rtl/i2s_transmitter.sv
// I2S stereo transmitter: 64-bclk frames with 16-bit samples, left-justified after the one-bclk
// I2S delay. A single pending pair is double-buffered into the shift words at each frame start.
module i2s_transmitter #(
    parameter int unsigned BCLK_DIV = 12
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] left_sample_in,
    input  logic [15:0] right_sample_in,
    input  logic        valid_in,
    output logic        i2s_bclk_out,
    output logic        i2s_lrclk_out,
    output logic        i2s_data_out,
    output logic        frame_start_out,
    output logic        underrun_out,
    output logic        overrun_out
);

    localparam int unsigned DivW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    typedef enum logic {StIdleWait, StRun} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            bclk_q, bclk_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            lrclk_q, lrclk_d;
    logic            data_q, data_d;
    logic [15:0]     cur_l_q, cur_l_d, cur_r_q, cur_r_d;
    logic [15:0]     pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic            flag_q, flag_d;
    logic            frame_q, frame_d, under_q, under_d, over_q, over_d;

    logic            div_end, fall, load;
    logic [5:0]      cnt_inc;
    logic [4:0]      slot_k;
    logic [3:0]      slot_idx;
    logic [15:0]     slot_word;
    logic            slot_bit;

    assign div_end = (div_q == DivW'(BCLK_DIV - 1));
    assign fall    = div_end && bclk_q;
    assign load    = fall && (cnt_q == 6'd63);
    assign cnt_inc = cnt_q + 6'd1;

    // Bit for the slot position being entered; slot 0 carries the one-bclk I2S delay.
    assign slot_k    = cnt_inc[4:0];
    assign slot_word = cnt_inc[5] ? cur_r_q : cur_l_q;
    assign slot_idx  = 4'(5'd16 - slot_k);
    assign slot_bit  = (slot_k != 5'd0 && slot_k <= 5'd16) ? slot_word[slot_idx] : 1'b0;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bclk_d   = bclk_q;
        cnt_d    = cnt_q;
        lrclk_d  = lrclk_q;
        data_d   = data_q;
        cur_l_d  = cur_l_q;
        cur_r_d  = cur_r_q;
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        flag_d   = flag_q;
        frame_d  = 1'b0;
        under_d  = 1'b0;
        over_d   = 1'b0;

        if (div_end) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + DivW'(1);
        end

        if (fall) begin
            cnt_d   = cnt_inc;
            lrclk_d = cnt_inc[5];
            data_d  = slot_bit;
        end

        if (load) begin
            if (flag_q) begin
                cur_l_d = pend_l_q;
                cur_r_d = pend_r_q;
                flag_d  = 1'b0;
                frame_d = 1'b1;
            end else begin
                under_d = 1'b1;
            end
        end

        // A pair arriving on the load cycle stays pending after the old one is consumed.
        if (valid_in) begin
            pend_l_d = left_sample_in;
            pend_r_d = right_sample_in;
            flag_d   = 1'b1;
            over_d   = flag_q && !load;
        end

        unique case (state_q)
            StIdleWait: if (fall) state_d = StRun;
            StRun:      state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StIdleWait;
            div_q    <= '0;
            bclk_q   <= 1'b0;
            cnt_q    <= 6'd63;
            lrclk_q  <= 1'b0;
            data_q   <= 1'b0;
            cur_l_q  <= '0;
            cur_r_q  <= '0;
            pend_l_q <= '0;
            pend_r_q <= '0;
            flag_q   <= 1'b0;
            frame_q  <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            cnt_q    <= cnt_d;
            lrclk_q  <= lrclk_d;
            data_q   <= data_d;
            cur_l_q  <= cur_l_d;
            cur_r_q  <= cur_r_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            flag_q   <= flag_d;
            frame_q  <= frame_d;
            under_q  <= under_d;
            over_q   <= over_d;
        end
    end

    assign i2s_bclk_out    = bclk_q;
    assign i2s_lrclk_out   = lrclk_q;
    assign i2s_data_out    = data_q;
    assign frame_start_out = frame_q;
    assign underrun_out    = under_q;
    assign overrun_out     = over_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter at BCLK_DIV=2: directed frame scenarios plus randomized traffic
// compared cycle by cycle against a timing-arithmetic reference model.
module tb_i2s_transmitter;

    localparam int unsigned D = 2;
    localparam int FT = 2 * D * 64;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] left_sample_in = '0;
    logic [15:0] right_sample_in = '0;
    logic        valid_in = 1'b0;
    logic        i2s_bclk_out, i2s_lrclk_out, i2s_data_out;
    logic        frame_start_out, underrun_out, overrun_out;

    i2s_transmitter #(.BCLK_DIV(D)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .left_sample_in  (left_sample_in),
        .right_sample_in (right_sample_in),
        .valid_in        (valid_in),
        .i2s_bclk_out    (i2s_bclk_out),
        .i2s_lrclk_out   (i2s_lrclk_out),
        .i2s_data_out    (i2s_data_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: position derived from clk edges since reset release.
    int          n;
    int          e_cnt;
    bit          e_fall;
    bit          e_bclk, e_lr, e_data, e_fs, e_ur, e_ov;
    logic [15:0] pend_l, pend_r, cur_l, cur_r;
    bit          m_flag;

    task automatic model_reset();
        n = 0; e_cnt = 63; e_fall = 0;
        e_bclk = 0; e_lr = 0; e_data = 0; e_fs = 0; e_ur = 0; e_ov = 0;
        pend_l = '0; pend_r = '0; cur_l = '0; cur_r = '0; m_flag = 0;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        left_sample_in = l;
        right_sample_in = r;
        valid_in = 1'b1;
    endtask

    task automatic tick();
        logic        v;
        logic [15:0] l, r, word;
        bit          load;
        int          k;
        v = valid_in; l = left_sample_in; r = right_sample_in;
        @(posedge clk_in);
        #1;
        n++;
        e_fall = (n % (2 * D) == 0);
        e_bclk = ((n / D) % 2) == 1;
        if (e_fall) e_cnt = (n / (2 * D) - 1) % 64;
        load = e_fall && (e_cnt == 0);
        e_fs = load && m_flag;
        e_ur = load && !m_flag;
        e_ov = v && m_flag && !load;
        if (load && m_flag) begin
            cur_l = pend_l;
            cur_r = pend_r;
        end
        if (load) m_flag = 0;
        if (v) begin
            pend_l = l;
            pend_r = r;
            m_flag = 1;
        end
        if (n >= 2 * D) begin
            e_lr = (e_cnt >= 32);
            k = e_cnt % 32;
            word = e_lr ? cur_r : cur_l;
            e_data = (k >= 1 && k <= 16) ? word[16 - k] : 1'b0;
        end else begin
            e_lr = 0;
            e_data = 0;
        end
        valid_in = 1'b0;
    endtask

    // Runs one frame from just after a load edge up to and including the next load edge.
    task automatic run_frame(input int at1, input logic [15:0] l1, input logic [15:0] r1,
                             input int at2, input logic [15:0] l2, input logic [15:0] r2,
                             output logic [15:0] cl, output logic [15:0] cr,
                             output int tail_nz, output int fs, output int ur, output int ov);
        cl = '0; cr = '0; tail_nz = 0; fs = 0; ur = 0; ov = 0;
        for (int i = 1; i <= FT; i++) begin
            if (i == at1) send(l1, r1);
            if (i == at2) send(l2, r2);
            tick();
            if (e_fall) begin
                if (e_cnt >= 1 && e_cnt <= 16) cl = {cl[14:0], i2s_data_out};
                if (e_cnt >= 33 && e_cnt <= 48) cr = {cr[14:0], i2s_data_out};
                if ((e_cnt % 32) >= 17 && i2s_data_out) tail_nz++;
            end
            fs += int'(frame_start_out);
            ur += int'(underrun_out);
            ov += int'(overrun_out);
        end
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst_in = 1'b1;
        #12;
        for (int i = 0; i < 2; i++) begin
            outs = {i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                    frame_start_out, underrun_out, overrun_out};
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected 000000", outs);
            end
            @(posedge clk_in); #1;
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic test_first_frame();
        logic [15:0] cl, cr;
        int tz, fs, ur, ov;
        send(16'hA5C3, 16'h8001);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (frame_start_out !== (i == 4)) begin
                n_fail++;
                $display("FAIL first_frame_start cycle %0d: got %b expected %b",
                         i, frame_start_out, (i == 4));
            end
        end
        run_frame(-1, '0, '0, -1, '0, '0, cl, cr, tz, fs, ur, ov);
        n_checks += 4;
        if (cl !== 16'hA5C3) begin n_fail++; $display("FAIL first_left: got %h expected a5c3", cl); end
        if (cr !== 16'h8001) begin n_fail++; $display("FAIL first_right: got %h expected 8001", cr); end
        if (tz !== 0) begin n_fail++; $display("FAIL first_tail_zero: got %0d ones expected 0", tz); end
        if (ur !== 1 || fs !== 0 || ov !== 0) begin
            n_fail++;
            $display("FAIL first_pulses: got fs=%0d ur=%0d ov=%0d expected 0 1 0", fs, ur, ov);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] cl, cr;
        int tz, fs, ur, ov;
        run_frame(-1, '0, '0, -1, '0, '0, cl, cr, tz, fs, ur, ov);
        n_checks += 2;
        if (cl !== 16'hA5C3 || cr !== 16'h8001) begin
            n_fail++;
            $display("FAIL underrun_retransmit: got %h/%h expected a5c3/8001", cl, cr);
        end
        if (ur !== 1 || fs !== 0) begin
            n_fail++;
            $display("FAIL underrun_count: got ur=%0d fs=%0d expected 1 0", ur, fs);
        end
    endtask

    task automatic test_clock_ratio();
        bit prev_b, prev_lr, prev_d, fell, rose;
        int last_rise, falls_hi, falls_lo, run;
        prev_b = i2s_bclk_out; prev_lr = i2s_lrclk_out; prev_d = i2s_data_out;
        last_rise = -1; falls_hi = 0; falls_lo = 0; run = 1;
        for (int i = 1; i <= 2 * FT; i++) begin
            tick();
            fell = prev_b && !i2s_bclk_out;
            rose = !prev_b && i2s_bclk_out;
            if (rose) begin
                if (last_rise >= 0) begin
                    n_checks++;
                    if (i - last_rise != 2 * D) begin
                        n_fail++;
                        $display("FAIL bclk_period: got %0d expected %0d", i - last_rise, 2 * D);
                    end
                end
                last_rise = i;
            end
            if (i2s_lrclk_out != prev_lr || i2s_data_out != prev_d) begin
                n_checks++;
                if (!fell) begin
                    n_fail++;
                    $display("FAIL change_on_fall at tick %0d: got bclk fall=%b expected 1", i, fell);
                end
            end
            if (fell) begin
                if (i2s_lrclk_out) falls_hi++; else falls_lo++;
                if (i2s_lrclk_out != prev_lr) begin
                    n_checks++;
                    if (run != 32) begin
                        n_fail++;
                        $display("FAIL lrclk_run: got %0d bclk expected 32", run);
                    end
                    run = 1;
                end else begin
                    run++;
                end
            end
            prev_b = i2s_bclk_out; prev_lr = i2s_lrclk_out; prev_d = i2s_data_out;
        end
        n_checks++;
        if (falls_hi != 64 || falls_lo != 64) begin
            n_fail++;
            $display("FAIL lrclk_ratio: got hi=%0d lo=%0d expected 64 64", falls_hi, falls_lo);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] cl, cr;
        int tz, fs, ur, ov;
        run_frame(10, 16'h1234, 16'h1111, 100, 16'h5678, 16'h2222, cl, cr, tz, fs, ur, ov);
        n_checks += 2;
        if (ov !== 1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", ov); end
        if (fs !== 1 || ur !== 0) begin
            n_fail++;
            $display("FAIL overrun_load: got fs=%0d ur=%0d expected 1 0", fs, ur);
        end
        run_frame(-1, '0, '0, -1, '0, '0, cl, cr, tz, fs, ur, ov);
        n_checks++;
        if (cl !== 16'h5678 || cr !== 16'h2222) begin
            n_fail++;
            $display("FAIL overrun_newest: got %h/%h expected 5678/2222", cl, cr);
        end
    endtask

    task automatic test_coincident();
        logic [15:0] cl, cr;
        int tz, fs, ur, ov;
        run_frame(50, 16'hCAFE, 16'hBEEF, FT, 16'h1357, 16'h2468, cl, cr, tz, fs, ur, ov);
        n_checks++;
        if (ov !== 0 || fs !== 1) begin
            n_fail++;
            $display("FAIL coincident_pulses: got ov=%0d fs=%0d expected 0 1", ov, fs);
        end
        run_frame(-1, '0, '0, -1, '0, '0, cl, cr, tz, fs, ur, ov);
        n_checks += 2;
        if (cl !== 16'hCAFE || cr !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL coincident_old: got %h/%h expected cafe/beef", cl, cr);
        end
        if (fs !== 1 || ov !== 0) begin
            n_fail++;
            $display("FAIL coincident_pending: got fs=%0d ov=%0d expected 1 0", fs, ov);
        end
        run_frame(-1, '0, '0, -1, '0, '0, cl, cr, tz, fs, ur, ov);
        n_checks++;
        if (cl !== 16'h1357 || cr !== 16'h2468 || ur !== 1) begin
            n_fail++;
            $display("FAIL coincident_new: got %h/%h ur=%0d expected 1357/2468 1", cl, cr, ur);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] cl, cr;
        logic [5:0] outs;
        int tz, fs, ur, ov;
        bit found;
        send(16'h0F0F, 16'hF0F0);
        found = 0;
        for (int i = 0; i < FT + 1 && !found; i++) begin
            tick();
            if (e_fall && e_cnt == 20) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL reset_mid_reach: got no count 20 expected one"); end
        for (int i = 0; i < D; i++) tick();
        #2;
        rst_in = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            outs = {i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                    frame_start_out, underrun_out, overrun_out};
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_mid_outputs %0d: got %b expected 000000", i, outs);
            end
            if (i < 3) begin @(posedge clk_in); #1; end
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (frame_start_out !== 1'b0 || underrun_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got fs=%b ur=%b expected 0 1",
                     frame_start_out, underrun_out);
        end
        run_frame(-1, '0, '0, -1, '0, '0, cl, cr, tz, fs, ur, ov);
        n_checks++;
        if (cl !== 16'h0 || cr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_lost: got %h/%h expected 0000/0000", cl, cr);
        end
    endtask

    task automatic test_random();
        logic [5:0] outs, exp;
        bit sent_prev;
        sent_prev = 0;
        for (int i = 0; i < 6 * FT; i++) begin
            if ($urandom_range(63) == 0 || (sent_prev && $urandom_range(3) == 0)) begin
                send(16'($urandom), 16'($urandom));
                sent_prev = 1;
            end else begin
                sent_prev = 0;
            end
            tick();
            outs = {i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                    frame_start_out, underrun_out, overrun_out};
            exp = {e_bclk, e_lr, e_data, e_fs, e_ur, e_ov};
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL random_outputs tick %0d: got %b expected %b", n, outs, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_underrun();
        test_clock_ratio();
        test_overrun();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 12, meaning bclk half-period in clk_in cycles (legal range >= 2).
REQ-002 SHALL have port clk_in  input  1  system clock, 100 MHz.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port left_sample_in  input  16  signed left sample.
REQ-005 SHALL have port right_sample_in  input  16  signed right sample.
REQ-006 SHALL have port valid_in  input  1  one-cycle pulse; the sample pair is valid.
REQ-007 SHALL have port i2s_bclk_out  output  1  bit clock to the DAC.
REQ-008 SHALL have port i2s_lrclk_out  output  1  word select; 0 = left, 1 = right.
REQ-009 SHALL have port i2s_data_out  output  1  serial data, MSB first.
REQ-010 SHALL have port frame_start_out  output  1  one-cycle pulse when a pair is loaded for transmission.
REQ-011 SHALL have port underrun_out  output  1  one-cycle pulse when a frame starts with no new pair.
REQ-012 SHALL have port overrun_out  output  1  one-cycle pulse when an unconsumed pending pair is overwritten.

Function
REQ-013 SHALL keep a divider counter 0..BCLK_DIV-1 and toggle i2s_bclk_out when the counter reaches BCLK_DIV-1, then wrap it to 0; default bclk is 100/24 = 4.167 MHz.
REQ-014 SHALL keep a 6-bit bit counter that advances (63 wraps to 0) on each clk_in edge where i2s_bclk_out goes 1->0 (the falling-edge event).
REQ-015 SHALL update i2s_lrclk_out and i2s_data_out only on falling-edge events, registered, on the same clk_in edge as the bclk 1->0 transition.
REQ-016 SHALL set i2s_lrclk_out = 0 for bit counts 0..31 and 1 for bit counts 32..63, giving 64 bclk per frame (lrclk = bclk/64).
REQ-017 SHALL drive i2s_data_out per slot bit k = count mod 32: k=0 -> 0; k=1..16 -> sample bit 16-k (one-bclk I2S delay, MSB first); k=17..31 -> 0.
REQ-018 SHALL use the left shift word in slot 0..31 and the right shift word in slot 32..63.
REQ-019 SHALL hold one pending pair register plus a pending-full flag; valid_in writes both samples and sets the flag.
REQ-020 SHALL, at the falling-edge event entering bit count 0, copy the pending pair into the shift words if the flag is set, clear the flag, and pulse frame_start_out.
REQ-021 SHALL, at bit count 0 with the flag clear, retransmit the previous shift words and pulse underrun_out; frame_start_out stays 0.
REQ-022 SHALL pulse overrun_out on valid_in while the flag is set and not being cleared that cycle; new data overwrites the old.
REQ-023 SHALL, when valid_in coincides with the frame-load event, load the old pending pair, keep the new pair pending with the flag set, and not pulse overrun_out.
REQ-024 SHALL have a latency of the next frame boundary plus one bclk, from accepted pair to MSB on i2s_data_out (bit count 1).
REQ-025 SHALL use the states IDLE_WAIT (after reset, until the first falling edge) and RUN; IDLE_WAIT->RUN at the first falling-edge event, which enters bit count 0.

Reset
REQ-026 SHALL, while rst_in = 1, immediately force i2s_bclk_out, i2s_lrclk_out, i2s_data_out, frame_start_out, underrun_out and overrun_out to 0.
REQ-027 SHALL, while rst_in = 1, set the divider to 0, the bit counter to 63, the shift words and pending pair to 0, the flag to 0, and the state to IDLE_WAIT.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame; after release the first frame starts at clk cycle 2*BCLK_DIV.

Verification
REQ-029 SHALL cover, with BCLK_DIV=2: reset, then valid_in with L=16'hA5C3, R=16'h8001 -> frame_start_out at cycle 4; data bits k=1..16 = A5C3 left and 8001 right; bits 17..31 = 0.
REQ-030 SHALL cover: check clock ratios over 2 frames -> bclk period 2*BCLK_DIV cycles; lrclk high exactly 32 bclk, low 32 bclk; lrclk and data change only on bclk falls.
REQ-031 SHALL cover: no valid_in for the second frame -> underrun_out pulses once at bit count 0; A5C3/8001 retransmitted.
REQ-032 SHALL cover: two valid_in pulses within one frame (L=1234 then L=5678) -> overrun_out pulses once; the next frame sends 5678.
REQ-033 SHALL cover: valid_in on the frame-load cycle -> no overrun_out; the old pair is sent now and the new pair next frame.
REQ-034 SHALL cover: rst_in asserted at bit count 20 for 3 cycles -> all outputs 0 asynchronously; after release the frame restarts and the pending pair is lost.
